// File: rtl/fod_phe_sampler.sv
// FOD phase-error sampler: bubble-filters each MPDIV8 ring sample, encodes the
// rising edge to a phase index and packs NLANE consecutive codes into PHE_X4.
module fod_phe_sampler #(
    parameter int MP_SEG_BIN = 3,
    parameter int MP_SEG     = 2 ** MP_SEG_BIN,
    parameter int NLANE      = 4,
    parameter int ERR_W      = 8
) (
    input  logic                        CLK,
    input  logic                        NARST,
    input  logic                        SAMP_EN,
    input  logic                        SYNC,
    input  logic [MP_SEG-1:0]           FMP_SAMP,
    output logic [NLANE*MP_SEG_BIN-1:0] PHE_X4,
    output logic                        PHE_VLD,
    output logic                        SAMP_ERR,
    output logic [ERR_W-1:0]            ERR_CNT
);
    localparam int LANE_W = (NLANE > 1) ? $clog2(NLANE) : 1;
    localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(NLANE - 1);

    // PHE_VLD is a one-cycle strobe with no back-pressure: the consumer must
    // take PHE_X4 on the cycle PHE_VLD is high; PHE_X4 then holds until the next word.
    typedef struct packed {
        logic              vld;
        logic [LANE_W-1:0] lane;
        logic              sync;
    } tag_t;

    tag_t                              s1_tag, s2_tag;
    logic [MP_SEG-1:0]                 s1_data, s2_data;
    logic [LANE_W-1:0]                 lane_cnt, lane_inc;
    logic [MP_SEG-1:0]                 s1_prev, s1_next, filt;
    logic [MP_SEG-1:0]                 c_prev, rise;
    logic                              enc_ok;
    logic [MP_SEG_BIN-1:0]             enc_code;
    logic [NLANE-1:0]                  fill_q, fill_nxt;
    logic [NLANE-1:0][MP_SEG_BIN-1:0]  slot_q, slot_nxt;

    assign lane_inc = (lane_cnt == LAST_LANE) ? '0 : lane_cnt + LANE_W'(1);

    always_ff @(posedge CLK or negedge NARST) begin
        if (!NARST) begin
            lane_cnt <= '0;
            s1_tag   <= '0;
            s1_data  <= '0;
        end else begin
            s1_data     <= FMP_SAMP;
            s1_tag.vld  <= SAMP_EN;
            s1_tag.lane <= SYNC ? '0 : lane_cnt;
            s1_tag.sync <= SYNC;
            if (SAMP_EN)
                lane_cnt <= SYNC ? LANE_W'(1) : lane_inc;
            else if (SYNC)
                lane_cnt <= '0;
        end
    end

    // Circular 3-tap majority removes single-phase bubbles around the ring
    assign s1_prev = {s1_data[MP_SEG-2:0], s1_data[MP_SEG-1]};
    assign s1_next = {s1_data[0], s1_data[MP_SEG-1:1]};
    assign filt    = (s1_prev & s1_data) | (s1_prev & s1_next) | (s1_data & s1_next);

    always_ff @(posedge CLK or negedge NARST) begin
        if (!NARST) begin
            s2_tag  <= '0;
            s2_data <= '0;
        end else begin
            s2_tag  <= s1_tag;
            s2_data <= filt;
        end
    end

    assign c_prev = {s2_data[MP_SEG-2:0], s2_data[MP_SEG-1]};
    assign rise   = s2_data & ~c_prev;
    assign enc_ok = (rise != '0) && ((rise & (rise - MP_SEG'(1))) == '0);

    always_comb begin
        enc_code = '0;
        for (int k = 0; k < MP_SEG; k++) begin
            if (rise[k])
                enc_code = MP_SEG_BIN'(k);
        end
    end

    // A sync tag restarts the partial word; an invalid code still marks its lane filled
    always_comb begin
        fill_nxt = (s2_tag.sync ? '0 : fill_q) | (NLANE'(1) << s2_tag.lane);
        slot_nxt = slot_q;
        if (enc_ok)
            slot_nxt[s2_tag.lane] = enc_code;
    end

    always_ff @(posedge CLK or negedge NARST) begin
        if (!NARST) begin
            fill_q   <= '0;
            slot_q   <= '0;
            PHE_X4   <= '0;
            PHE_VLD  <= 1'b0;
            SAMP_ERR <= 1'b0;
            ERR_CNT  <= '0;
        end else if (s2_tag.vld) begin
            slot_q   <= slot_nxt;
            SAMP_ERR <= !enc_ok;
            if (!enc_ok && (ERR_CNT != '1))
                ERR_CNT <= ERR_CNT + ERR_W'(1);
            if ((s2_tag.lane == LAST_LANE) && (fill_nxt == '1)) begin
                PHE_X4  <= slot_nxt;
                PHE_VLD <= 1'b1;
                fill_q  <= '0;
            end else begin
                PHE_VLD <= 1'b0;
                fill_q  <= fill_nxt;
            end
        end else begin
            PHE_VLD  <= 1'b0;
            SAMP_ERR <= 1'b0;
            if (s2_tag.sync)
                fill_q <= '0;
        end
    end
endmodule

// File: tb/tb_fod_phe_sampler.sv
// Directed + random bench for fod_phe_sampler with a word scoreboard.
module tb_fod_phe_sampler;
    logic        CLK = 1'b0;
    logic        NARST;
    logic        SAMP_EN;
    logic        SYNC;
    logic [7:0]  FMP_SAMP;
    logic [11:0] PHE_X4;
    logic        PHE_VLD;
    logic        SAMP_ERR;
    logic [7:0]  ERR_CNT;

    int n_assert = 0;
    int n_fail   = 0;
    int vld_seen = 0;
    int err_seen = 0;
    int m_errp   = 0;
    int m_err    = 0;
    int m_lane   = 0;
    logic [3:0]  m_fill = '0;
    logic [2:0]  m_slot [4] = '{3'd0, 3'd0, 3'd0, 3'd0};
    logic [11:0] exp_q[$];
    logic [7:0]  bad_pat [3] = '{8'h00, 8'hFF, 8'h55};
    int vld_base;
    int en_cnt;
    logic en_r;

    fod_phe_sampler dut (
        .CLK      (CLK),
        .NARST    (NARST),
        .SAMP_EN  (SAMP_EN),
        .SYNC     (SYNC),
        .FMP_SAMP (FMP_SAMP),
        .PHE_X4   (PHE_X4),
        .PHE_VLD  (PHE_VLD),
        .SAMP_ERR (SAMP_ERR),
        .ERR_CNT  (ERR_CNT)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_assert++;
        assert (got === want) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, want);
        end
    endtask

    // Ring sample whose rising edge sits at phase 'code' (four phases high)
    function automatic logic [7:0] therm(input int code);
        logic [15:0] w;
        w = 16'h0F0F << code;
        return w[15:8];
    endfunction

    // Returns {ok, code}: majority filter by modular index, then count rising edges
    function automatic logic [3:0] enc(input logic [7:0] s);
        logic [7:0] c;
        int         nr;
        int         a;
        logic [2:0] code;
        nr   = 0;
        code = '0;
        for (int k = 0; k < 8; k++) begin
            a    = int'(s[(k + 7) % 8]) + int'(s[k]) + int'(s[(k + 1) % 8]);
            c[k] = (a >= 2);
        end
        for (int k = 0; k < 8; k++) begin
            if (c[k] && !c[(k + 7) % 8]) begin
                nr++;
                code = 3'(k);
            end
        end
        return {(nr == 1), code};
    endfunction

    task automatic model_apply(input int lane, input logic sync, input logic [7:0] samp);
        logic [3:0] e;
        e = enc(samp);
        if (e[3]) m_slot[lane] = e[2:0];
        else begin
            m_errp++;
            if (m_err < 255) m_err++;
        end
        if (sync) m_fill = '0;
        m_fill[lane] = 1'b1;
        if (lane == 3 && m_fill == 4'hF) begin
            exp_q.push_back({m_slot[3], m_slot[2], m_slot[1], m_slot[0]});
            m_fill = '0;
        end
    endtask

    task automatic model_reset();
        m_lane = 0;
        m_fill = '0;
        m_err  = 0;
        m_errp = 0;
        err_seen = 0;
        for (int i = 0; i < 4; i++) m_slot[i] = '0;
        exp_q.delete();
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic drive(input logic en, input logic sync, input logic [7:0] samp);
        int lane;
        SAMP_EN  = en;
        SYNC     = sync;
        FMP_SAMP = samp;
        if (en) begin
            lane   = sync ? 0 : m_lane;
            m_lane = sync ? 1 : (m_lane + 1) % 4;
            model_apply(lane, sync, samp);
        end else if (sync) begin
            m_lane = 0;
            m_fill = '0;
        end
        tick();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 8'($urandom_range(0, 255)));
    endtask

    always @(negedge CLK) begin
        if (SAMP_ERR === 1'b1) err_seen++;
        if (PHE_VLD === 1'b1) begin
            vld_seen++;
            check("vld_has_expected_word", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) check("word", 32'(PHE_X4), 32'(exp_q.pop_front()));
        end
    end

    initial begin
        NARST = 1'b0; SAMP_EN = 1'b0; SYNC = 1'b0; FMP_SAMP = '0;
        // T1: reset held with toggling inputs
        for (int i = 0; i < 4; i++) begin
            SAMP_EN  = 1'($urandom_range(0, 1));
            SYNC     = 1'($urandom_range(0, 1));
            FMP_SAMP = 8'($urandom_range(0, 255));
            tick();
        end
        check("rst_phe_x4", 32'(PHE_X4), 32'h0);
        check("rst_phe_vld", 32'(PHE_VLD), 32'h0);
        check("rst_err_cnt", 32'(ERR_CNT), 32'h0);
        check("rst_samp_err", 32'(SAMP_ERR), 32'h0);
        SAMP_EN = 1'b0; SYNC = 1'b0;
        NARST = 1'b1;
        idle(2);

        // T2: clean frame and latency
        drive(1'b1, 1'b1, 8'h3C);
        drive(1'b1, 1'b0, 8'h78);
        drive(1'b1, 1'b0, 8'hF0);
        drive(1'b1, 1'b0, 8'hE1);
        check("t2_vld_edge1", 32'(PHE_VLD), 32'h0);
        idle(1);
        check("t2_vld_edge2", 32'(PHE_VLD), 32'h0);
        idle(1);
        check("t2_vld_edge3", 32'(PHE_VLD), 32'h1);
        check("t2_word", 32'(PHE_X4), 32'hB1A);
        idle(1);
        check("t2_vld_one_cycle", 32'(PHE_VLD), 32'h0);
        check("t2_word_held", 32'(PHE_X4), 32'hB1A);
        check("t2_err_cnt", 32'(ERR_CNT), 32'h0);

        // T3: bubble corrected sample in lane 1
        drive(1'b1, 1'b1, therm(0));
        drive(1'b1, 1'b0, 8'h34);
        drive(1'b1, 1'b0, therm(6));
        drive(1'b1, 1'b0, therm(7));
        idle(3);
        check("t3_word", 32'(PHE_X4), 32'hF98);
        check("t3_err_cnt", 32'(ERR_CNT), 32'h0);

        // T4: invalid lane-1 samples keep the previous lane-1 code (3)
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b1, therm(1));
            drive(1'b1, 1'b0, bad_pat[i]);
            check("t4_samp_err_early", 32'(SAMP_ERR), 32'h0);
            drive(1'b1, 1'b0, therm(2));
            drive(1'b1, 1'b0, therm(3));
            check("t4_samp_err_pulse", 32'(SAMP_ERR), 32'h1);
            idle(1);
            check("t4_samp_err_clear", 32'(SAMP_ERR), 32'h0);
            idle(2);
            check("t4_word", 32'(PHE_X4), 32'h699);
            check("t4_err_cnt", 32'(ERR_CNT), 32'(i + 1));
        end
        check("t4_err_pulses", 32'(err_seen), 32'(m_errp));

        // T1b: reset asserted mid-word clears outputs at once
        drive(1'b1, 1'b1, therm(4));
        drive(1'b1, 1'b0, therm(5));
        #2 NARST = 1'b0;
        #1;
        check("midrst_phe_x4", 32'(PHE_X4), 32'h0);
        check("midrst_phe_vld", 32'(PHE_VLD), 32'h0);
        check("midrst_err_cnt", 32'(ERR_CNT), 32'h0);
        check("midrst_samp_err", 32'(SAMP_ERR), 32'h0);
        SAMP_EN = 1'b0; SYNC = 1'b0;
        model_reset();
        tick();
        NARST = 1'b1;
        drive(1'b1, 1'b0, therm(7));
        drive(1'b1, 1'b0, therm(0));
        drive(1'b1, 1'b0, therm(5));
        drive(1'b1, 1'b0, therm(2));
        idle(3);
        check("post_rst_word", 32'(PHE_X4), 32'h547);

        // T4b: error counter saturation
        for (int i = 0; i < 300; i++) drive(1'b1, 1'b0, 8'h00);
        idle(3);
        check("sat_err_cnt", 32'(ERR_CNT), 32'd255);
        check("sat_err_pulses", 32'(err_seen), 32'(m_errp));
        for (int i = 0; i < 5; i++) drive(1'b1, 1'b0, 8'hFF);
        idle(3);
        check("sat_err_cnt_hold", 32'(ERR_CNT), 32'd255);
        check("sat_model_cnt", 32'(ERR_CNT), 32'(m_err));

        // T5: SYNC on the 3rd sample restarts the word
        vld_base = vld_seen;
        drive(1'b1, 1'b1, therm(5));
        drive(1'b1, 1'b0, therm(6));
        drive(1'b1, 1'b1, therm(1));
        drive(1'b1, 1'b0, therm(2));
        drive(1'b1, 1'b0, therm(3));
        idle(3);
        check("t5_no_early_vld", 32'(vld_seen - vld_base), 32'd0);
        drive(1'b1, 1'b0, therm(4));
        idle(3);
        check("t5_word", 32'(PHE_X4), 32'h8D1);
        check("t5_vld_count", 32'(vld_seen - vld_base), 32'd1);

        // T6: random SAMP_EN gaps with a valid-code stream
        drive(1'b0, 1'b1, 8'($urandom_range(0, 255)));
        vld_base = vld_seen;
        en_cnt = 0;
        for (int i = 0; i < 200; i++) begin
            en_r = 1'($urandom_range(0, 1));
            drive(en_r, 1'b0, therm($urandom_range(0, 7)));
            if (en_r) en_cnt++;
        end
        while (en_cnt % 4 != 0) begin
            drive(1'b1, 1'b0, therm($urandom_range(0, 7)));
            en_cnt++;
        end
        idle(4);
        check("t6_vld_count", 32'(vld_seen - vld_base), 32'(en_cnt / 4));
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        check("final_err_pulses", 32'(err_seen), 32'(m_errp));

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
